// File: rtl/alu_exec.sv
// alu_exec -- multi-cycle execute-stage ALU.
//
// Add, sub and the logic ops finish in one cycle. Shifts go through a
// serial shifter that moves one bit position per cycle. Requests and results
// each use a valid/ready handshake, so the pipeline can stall on long shifts.
// Build option ALU_EXEC_BARREL_SHIFT_EN swaps in a combinational barrel
// shifter, which gives every op a latency of one cycle. The results and flags
// are the same in both builds.
//
// Ports:
//   clk, rst             clock (rising edge), synchronous active-high reset
//   flush                abandon any in-flight op (pipeline redirect)
//   in_valid/in_ready    request handshake; alu_control/src_a/src_b are
//                        sampled on transfer
//   alu_control          000 add 001 sub 010 and 011 or 100 xor
//                        101 sll 110 srl 111 sra
//   src_a, src_b         operands; shift amount = src_b[SHW-1:0]
//   out_valid/out_ready  result handshake
//   result               registered result
//   zero, lt, ltu        result==0, signed/unsigned A<B (sub only, else 0)
//   busy                 state != IDLE
module alu_exec #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            lt,
  output logic            ltu,
  output logic            busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t state_q, state_d;

  logic            xfer;
  logic            is_sub;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] b_eff;
  logic [XLEN:0]   sum_w;
  logic            ovf;
  logic [XLEN-1:0] res_c;
  logic            lt_c, ltu_c;

  logic [XLEN-1:0] result_p1;
  logic            zero_p1, lt_p1, ltu_p1;

  assign xfer   = in_valid && in_ready;
  assign is_sub = (alu_control == OP_SUB);
  assign shamt  = src_b[SHW-1:0];

  // Single-cycle datapath. Sub is A + ~B + 1, and the carry-out doubles as
  // the "no borrow" flag for the unsigned compare.
  always_comb begin
    b_eff = is_sub ? ~src_b : src_b;
    sum_w = {1'b0, src_a} + {1'b0, b_eff} + {{XLEN{1'b0}}, is_sub};
    ovf   = (src_a[XLEN-1] != src_b[XLEN-1]) && (sum_w[XLEN-1] != src_a[XLEN-1]);
    lt_c  = is_sub && (sum_w[XLEN-1] ^ ovf);
    ltu_c = is_sub && !sum_w[XLEN];
    res_c = sum_w[XLEN-1:0];
    case (alu_control)
      OP_ADD, OP_SUB: res_c = sum_w[XLEN-1:0];
      OP_AND:         res_c = src_a & src_b;
      OP_OR:          res_c = src_a | src_b;
      OP_XOR:         res_c = src_a ^ src_b;
`ifdef ALU_EXEC_BARREL_SHIFT_EN
      OP_SLL:         res_c = src_a << shamt;
      OP_SRL:         res_c = src_a >> shamt;
      OP_SRA:         res_c = XLEN'($signed(src_a) >>> shamt);
`else
      // Only the zero-amount case takes this path. It returns src_a directly.
      OP_SLL, OP_SRL, OP_SRA: res_c = src_a;
`endif
      default:        res_c = sum_w[XLEN-1:0];
    endcase
  end

`ifndef ALU_EXEC_BARREL_SHIFT_EN
  logic            shift_start;
  logic [XLEN-1:0] acc_p1, acc_nxt;
  logic [SHW-1:0]  cnt_p1;
  logic [1:0]      sop_p1;
  logic            shift_last;

  // One-bit shift step. The op code is 01 for sll, 10 for srl and 11 for sra.
  function automatic logic [XLEN-1:0] shift1(input logic [1:0] sop,
                                             input logic [XLEN-1:0] v);
    logic signed [XLEN-1:0] vs;
    vs = $signed(v);
    case (sop)
      2'b01:   shift1 = {v[XLEN-2:0], 1'b0};
      2'b10:   shift1 = {1'b0, v[XLEN-1:1]};
      default: shift1 = XLEN'(vs >>> 1);
    endcase
  endfunction

  assign shift_start = xfer && alu_control[2] && (alu_control[1:0] != 2'b00)
                       && (shamt != '0);
  assign acc_nxt     = shift1(sop_p1, acc_p1);
  assign shift_last  = (state_q == SHIFT) && (cnt_p1 == SHW'(1));

  // Serial shifter working state. It is data only, so rst does not touch it.
  always_ff @(posedge clk) begin
    if (shift_start) begin
      acc_p1 <= src_a;
      cnt_p1 <= shamt;
      sop_p1 <= alu_control[1:0];
    end else if (state_q == SHIFT) begin
      acc_p1 <= acc_nxt;
      cnt_p1 <= cnt_p1 - SHW'(1);
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic. A flush overrides every state. It also blocks
  // transfer, because in_ready is low while flush is high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
`ifndef ALU_EXEC_BARREL_SHIFT_EN
          state_d = shift_start ? SHIFT : DONE;
`else
          state_d = DONE;
`endif
        end
      end
`ifndef ALU_EXEC_BARREL_SHIFT_EN
      SHIFT: if (cnt_p1 == SHW'(1)) state_d = DONE;
`endif
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // FSM outputs
  always_comb begin
    in_ready  = (state_q == IDLE) && !flush;
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  // Result stage. The result is written on a one-cycle transfer or on the
  // final serial shift, and is then held until the next op.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_p1 <= '0;
      zero_p1   <= 1'b1;
      lt_p1     <= 1'b0;
      ltu_p1    <= 1'b0;
`ifndef ALU_EXEC_BARREL_SHIFT_EN
    end else if (xfer && !shift_start) begin
`else
    end else if (xfer) begin
`endif
      result_p1 <= res_c;
      zero_p1   <= (res_c == '0);
      lt_p1     <= lt_c;
      ltu_p1    <= ltu_c;
`ifndef ALU_EXEC_BARREL_SHIFT_EN
    end else if (shift_last && !flush) begin
      result_p1 <= acc_nxt;
      zero_p1   <= (acc_nxt == '0);
      lt_p1     <= 1'b0;
      ltu_p1    <= 1'b0;
`endif
    end
  end

  assign result = result_p1;
  assign zero   = zero_p1;
  assign lt     = lt_p1;
  assign ltu    = ltu_p1;

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;
  localparam int XLEN = 32;
`ifdef ALU_EXEC_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic        zero, lt, ltu, busy;
  logic [2:0]  alu_control;
  logic [31:0] src_a, src_b, result;

  int passed = 0;
  int total  = 0;
  int waited;

  always #5 clk = ~clk;

  alu_exec #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .lt(lt), .ltu(ltu), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain arithmetic on the operands.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic l, output logic lu,
                       output int lat);
    int n;
    n = int'(b[4:0]);
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << n;
      3'd6: r = a >> n;
      default: r = 32'($signed(a) >>> n);
    endcase
    l   = (op == 3'd1) && ($signed(a) < $signed(b));
    lu  = (op == 3'd1) && (a < b);
    lat = (op >= 3'd5 && !BARREL) ? n : 0;
  endtask

  // Presents one request and returns right after the transfer edge.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 50 && !in_ready; i++) tick();
    chk("send_in_ready", in_ready, 1);
    in_valid = 1'b1; alu_control = op; src_a = a; src_b = b;
    tick();
    in_valid = 1'b0; alu_control = 3'($urandom); src_a = $urandom; src_b = $urandom;
  endtask

  task automatic wait_out();
    waited = 0;
    while (!out_valid && waited < 100) begin tick(); waited++; end
  endtask

  task automatic check_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r; logic l, lu; int lat;
    model(op, a, b, r, l, lu, lat);
    send(op, a, b);
    wait_out();
    chk({tag, "_lat"}, 32'(waited), 32'(lat));
    chk({tag, "_res"}, result, r);
    chk({tag, "_zero"}, zero, (r == 0));
    chk({tag, "_lt"}, lt, l);
    chk({tag, "_ltu"}, ltu, lu);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_ov_after"}, out_valid, 0);
    chk({tag, "_rdy_after"}, in_ready, 1);
  endtask

  initial begin
    logic [31:0] r; logic l, lu; int lat;
    logic [2:0] op; logic [31:0] a, b;
    logic seen, fl;
    int k;

    // Reset with a request pending: no transfer may happen.
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; alu_control = 3'd0; src_a = 32'd5; src_b = 32'd7;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_zero", zero, 1);
    chk("rst_result", result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lt", {lt, ltu}, 0);
    tick();
    chk("rst_no_xfer", out_valid, 0);

    // Sub directed vectors
    check_op("sub57", 3'd1, 32'h5, 32'h7);
    chk("sub57_lit", {result[31:0]}, 32'hFFFFFFFE);
    chk("sub57_flags", {29'd0, lt, ltu, zero}, 32'b110);
    consume("sub57");
    check_op("submin", 3'd1, 32'h80000000, 32'h1);
    chk("submin_lit", result, 32'h7FFFFFFF);
    chk("submin_flags", {30'd0, lt, ltu}, 32'b10);
    consume("submin");

    // sra by 4 and sll by 0
    check_op("sra4", 3'd7, 32'h80000010, 32'h24);
    chk("sra4_lit", result, 32'hF8000001);
    consume("sra4");
    check_op("sll0", 3'd5, 32'h12345678, 32'h20);
    chk("sll0_lit", result, 32'h12345678);
    consume("sll0");

    // Backpressure: result held while out_ready stays low
    send(3'd0, 32'hFFFFFFFF, 32'h1);
    wait_out();
    chk("bp_lat", 32'(waited), 0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_result", result, 0);
      chk("bp_zero", zero, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      tick();
    end
    consume("bp");

`ifndef ALU_EXEC_BARREL_SHIFT_EN
    // Flush in the middle of a serial shift
    send(3'd6, 32'hFFFF0000, 32'd20);
    tick(); tick();
    flush = 1'b1;
    #1;
    chk("fl_in_ready_during", in_ready, 0);
    chk("fl_busy_during", busy, 1);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_in_ready_after", in_ready, 1);
    chk("fl_busy_after", busy, 0);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin seen = seen | out_valid; tick(); end
    chk("fl_no_out_valid", seen, 0);
`endif
    check_op("and", 3'd2, 32'hF0F0F0F0, 32'h0FF00FF0);
    chk("and_lit", result, 32'h00F000F0);
    consume("and");

    // Random ops with random backpressure and flush
    for (int it = 0; it < 150; it++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) a = {32{a[0]}};
      if (op == 3'd1 && $urandom_range(0, 3) == 0) b = a;
      model(op, a, b, r, l, lu, lat);
      check_op("rnd", op, a, b);
      k = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) begin
        tick();
        chk("rnd_hold_res", result, r);
        chk("rnd_hold_rdy", {out_valid, in_ready}, 32'b10);
      end
      fl = ($urandom_range(0, 3) == 0);
      flush = fl;
      out_ready = fl ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      flush = 1'b0; out_ready = 1'b0;
      #1;
      chk("rnd_ov_after", out_valid, 0);
      chk("rnd_rdy_after", in_ready, 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
